modn_updown_chain: RTL
======================

# modn_updown_chain

Parametrised cascade of DIGITS modulo-MOD up/down counter digits with count enable, synchronous parallel load, asynchronous clear and cascadable carry/borrow outputs. It is the general-purpose successor to the team's single-digit mod-6 up/down counter. It serves as the time-base and event counter for display/timer blocks (for example, seconds/minutes with MOD=6 and MOD=10 stages). The whole chain behaves as one DIGITS-digit base-MOD number.

## Interface
- MOD, 6, modulus of every digit; legal range 2..16.
- DIGITS, 2, number of cascaded digits; legal range 1..8.
- W (localparam), clog2(MOD), bits per digit; MOD=6 gives W=3.
- CP  in  1  clock; all state changes on rising edge.
- CLR_  in  1  asynchronous, active-low clear. One clock (CP), reset asynchronous active-low, as decided.
- EN  in  1  count enable; 0 holds Q.
- U  in  1  direction; 1 = up, 0 = down.
- LD  in  1  synchronous parallel load.
- D  in  DIGITS*W  load value; digit i at D[i*W +: W]; digit 0 is least significant.
- Q  out  DIGITS*W  count, packed the same way as D.
- CO  out  1  carry out: EN & U & CLR_ & (every digit == MOD-1).
- BO  out  1  borrow out: EN & ~U & CLR_ & (every digit == 0).

## Operation
- Priority, highest first: CLR_ low, then LD, then EN, then hold.
- CLR_ low: Q = 0 immediately, independent of CP. CO = BO = 0 while CLR_ is low.
- LD=1 at an edge: each digit i loads D digit i. A digit value ≥ MOD loads 0 for that digit only. EN and U are ignored in that cycle.
- EN=1, LD=0: digit 0 steps every edge. Digit i>0 steps only when all lower digits are at terminal: MOD-1 when U=1, 0 when U=0.
- Up step: v → v+1; MOD-1 wraps to 0.
- Down step: v → v-1; 0 wraps to MOD-1.
- Whole-chain wrap: all MOD-1 counting up gives all 0 with CO=1 in the preceding cycle. All 0 counting down gives all MOD-1 with BO=1 in the preceding cycle.
- Invariant: outside reset every digit is < MOD. Arithmetic is W bits wide with explicit wrap compare, not a % operator.
- U may change on any cycle; the next edge uses the new direction, with no glitch state.
- Cascading: CO/BO of one chain drives EN of the next chain; U is shared between chains.

## Timing
- Q is registered with 1-cycle latency from EN/LD/U sampled at the CP edge.
- CO/BO are combinational from Q, EN, U and CLR_, valid the same cycle. They assert for exactly the one cycle preceding the wrap edge when EN is held at 1.
- CLR_ deassertion takes effect at the first CP edge after release; Q stays 0 until then. No recovery requirement is stated beyond standard async-reset timing.
- Reset values: Q = 0, CO = 0, BO = 0.
- Carry enable across the chain is combinational lookahead. The per-digit terminal AND adds no cycle of delay.

## Structure
- Shared package counter_pkg:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a width helper for clog2(MOD);
  - the MOD and DIGITS legality limits.
- Sub-module modn_digit (parameter MOD), one instance per digit:
  - inputs CP, CLR_, step, U, ld, d;
  - outputs q and term, where term = (U ? q==MOD-1 : q==0).
- Top level:
  - generate loop over the digits;
  - step[i] = EN & ~LD & AND(term[0..i-1]);
  - CO/BO from AND(term[all]).
- Parameter checks at elaboration: MOD outside 2..16 or DIGITS outside 1..8 is a fatal error.

## Test plan
All scenarios use MOD=6, DIGITS=2; Q is written as digits {d1,d0}.
- Reset then up-count: CLR_ low, then high, U=1, EN=1, 6 edges → Q={0,5} after 5 edges and {1,0} after 6 edges. CO stays 0 throughout.
- Full up wrap: LD with D={5,4}, then U=1, EN=1 → edge 1 gives Q={5,5} with CO=1 that cycle; edge 2 gives Q={0,0} with CO=0.
- Down wrap: Q={0,0}, U=0, EN=1 → BO=1 before the edge; after the edge Q={5,5} and BO=0. With EN=0 and Q={0,0}, BO=0.
- Load priority and range: LD=1, EN=1, D={2,7} → Q={2,0}. Digit 0 is out of range and loads 0; there is no count step in that cycle.
- Async clear mid-count: Q={3,4} counting; CLR_ pulsed low between edges → Q={0,0} before the next CP edge, CO/BO=0. Counting resumes from {0,1}.
- Hold and direction change: EN=0 for 3 edges → Q unchanged. Then U toggles every edge at Q={1,0} with EN=1 → the sequence {1,1}, {1,0}, {1,1} (up, down, up).

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the mod-N up/down counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MOD_MIN    = 2;
  localparam int MOD_MAX    = 16;
  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  // Bits needed to hold 0..m-1; never less than one bit.
  function automatic int digit_width(input int m);
    int w;
    w = 1;
    while ((1 << w) < m) w++;
    return w;
  endfunction

endpackage

// File: rtl/modn_updown_chain_digit.sv
// One base-MOD up/down digit with load, step enable and terminal-count flag.
module modn_digit
  import counter_pkg::*;
#(
  parameter int MOD = 6,
  localparam int W  = digit_width(MOD)
) (
  input  logic         CP,
  input  logic         CLR_,
  input  logic         step,
  input  logic         U,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         term
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [W-1:0] q_up, q_dn, d_ok;

  // Explicit wrap compares keep the digit inside 0..MOD-1 without a modulo.
  assign q_up = (q == MAXV)  ? '0   : q + W'(1);
  assign q_dn = (q == '0)    ? MAXV : q - W'(1);
  assign d_ok = (d > MAXV)   ? '0   : d;

  assign term = (U == DIR_UP) ? (q == MAXV) : (q == '0);

  always_ff @(posedge CP or negedge CLR_) begin
    if (!CLR_)     q <= '0;
    else if (ld)   q <= d_ok;
    else if (step) q <= (U == DIR_UP) ? q_up : q_dn;
  end

endmodule

// File: rtl/modn_updown_chain.sv
// Cascade of DIGITS base-MOD up/down digits acting as one multi-digit number.
module modn_updown_chain
  import counter_pkg::*;
#(
  parameter int MOD    = 6,
  parameter int DIGITS = 2,
  localparam int W     = digit_width(MOD)
) (
  input  logic                CP,
  input  logic                CLR_,
  input  logic                EN,
  input  logic                U,
  input  logic                LD,
  input  logic [DIGITS*W-1:0] D,
  output logic [DIGITS*W-1:0] Q,
  output logic                CO,
  output logic                BO
);

  if (MOD < MOD_MIN || MOD > MOD_MAX) begin : g_bad_mod
    $fatal(1, "modn_updown_chain: MOD=%0d outside legal range", MOD);
  end
  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $fatal(1, "modn_updown_chain: DIGITS=%0d outside legal range", DIGITS);
  end

  logic [DIGITS-1:0][W-1:0] d_arr, q_arr;
  logic [DIGITS-1:0]        term, step;
  // low_term[i]: every digit below i sits at its terminal value (lookahead AND).
  logic [DIGITS:0]          low_term;

  assign d_arr       = D;
  assign Q           = q_arr;
  assign low_term[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign low_term[i+1] = low_term[i] & term[i];
    assign step[i]       = EN & ~LD & low_term[i];

    modn_digit #(.MOD(MOD)) u_dig (
      .CP   (CP),
      .CLR_ (CLR_),
      .step (step[i]),
      .U    (U),
      .ld   (LD),
      .d    (d_arr[i]),
      .q    (q_arr[i]),
      .term (term[i])
    );
  end

  assign CO = EN & (U == DIR_UP)   & CLR_ & low_term[DIGITS];
  assign BO = EN & (U == DIR_DOWN) & CLR_ & low_term[DIGITS];

endmodule
